// File: rtl/channel_in_group_acc_pkg.sv
// rtl/channel_in_group_acc_pkg.sv - shared Para defines, lane geometry and FSM encodings
// Macros stand in for the shared Para include so the lane geometry has a single source.
`ifndef PICTURE_NUM
`define PICTURE_NUM 8
`endif
`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 16
`endif

package channel_in_group_acc_pkg;
  localparam int PICTURE_NUM          = `PICTURE_NUM;
  localparam int LANE_W               = `WIDTH_DATA_OUT * 2;
  localparam int DATA_W               = PICTURE_NUM * LANE_W;
  localparam int TREE_LATENCY_DEFAULT = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Two's complement add at lane width; the carry out is dropped so lanes wrap.
  function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
    return a + b;
  endfunction
endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - parameterised 1-bit shift register with async reset
module valid_delay_line #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/channel_in_group_acc.sv
// rtl/channel_in_group_acc.sv - accumulates N adder-tree beats per output pixel across P pixels
// valid_in is delayed to line up with the tree output; data_in is already tree-aligned.
module channel_in_group_acc
  import channel_in_group_acc_pkg::*;
#(
  parameter int TREE_LATENCY = TREE_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       channel_in_times,
  input  logic [19:0]       pixel_total,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              busy,
  output logic              done
);
  logic              v_al;
  logic [1:0]        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [19:0]       p_q, p_d;
  logic [15:0]       beat_q, beat_d;
  logic [19:0]       pix_q, pix_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] sum;

  valid_delay_line #(.DEPTH(TREE_LATENCY)) u_valid_delay_line (
    .clk  (clk),
    .rst  (rst),
    .din  (valid_in),
    .dout (v_al)
  );

  // The first beat of a pixel loads rather than adds, so no explicit acc clear is needed.
  always_comb begin
    sum = '0;
    for (int l = 0; l < PICTURE_NUM; l++) begin
      if (beat_q == 16'd0) sum[l*LANE_W +: LANE_W] = data_in[l*LANE_W +: LANE_W];
      else sum[l*LANE_W +: LANE_W] = lane_add(acc_q[l*LANE_W +: LANE_W],
                                              data_in[l*LANE_W +: LANE_W]);
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_d     = p_q;
    beat_d  = beat_q;
    pix_d   = pix_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          n_d     = (channel_in_times == 16'd0) ? 16'd1 : channel_in_times;
          p_d     = pixel_total;
          beat_d  = 16'd0;
          pix_d   = 20'd0;
        end
      end
      ST_RUN: begin
        if (p_q == 20'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (v_al) begin
          acc_d = sum;
          if (beat_q == n_q - 16'd1) begin
            dout_d  = sum;
            valid_d = 1'b1;
            beat_d  = 16'd0;
            pix_d   = pix_q + 20'd1;
            if (pix_q + 20'd1 == p_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      p_q     <= '0;
      beat_q  <= '0;
      pix_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      beat_q  <= beat_d;
      pix_q   <= pix_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = valid_q;
  assign done           = done_q;
  assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_channel_in_group_acc.sv
// tb/tb_channel_in_group_acc.sv - directed self-checking bench for channel_in_group_acc
module tb_channel_in_group_acc;
  import channel_in_group_acc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       n_in;
  logic [19:0]       p_in;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              busy;
  logic              done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [DATA_W-1:0] out_q[$];
  logic              done_at[$];
  int                cyc_at[$];
  logic [DATA_W-1:0] dq[0:6];

  channel_in_group_acc #(.TREE_LATENCY(7)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .channel_in_times (n_in),
    .pixel_total      (p_in),
    .valid_in         (valid_in),
    .data_in          (data_in),
    .data_out         (data_out),
    .data_out_valid   (data_out_valid),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_out_valid) begin
      out_q.push_back(data_out);
      done_at.push_back(done);
      cyc_at.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  function automatic logic [DATA_W-1:0] all_lanes(input logic [31:0] v);
    logic [DATA_W-1:0] r;
    for (int l = 0; l < PICTURE_NUM; l++) r[l*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] one_lane(input int l, input logic [31:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[l*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  function automatic logic [31:0] ln(input logic [DATA_W-1:0] v, input int l);
    return v[l*LANE_W +: LANE_W];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Models the adder tree: data for a valid_in beat reaches data_in 7 cycles later.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic s);
    data_in = dq[6];
    for (int i = 6; i > 0; i--) dq[i] = dq[i-1];
    dq[0] = d;
    valid_in = v;
    start = s;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    int n0;
    int d0;
    int c_first;
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; data_in = '0;
    n_in = '0; p_in = '0;
    for (int i = 0; i < 7; i++) dq[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(|data_out), 32'd0);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    idle(2);

    // N=8, P=2, every lane sees 1..8 twice
    n_in = 16'd8; p_in = 20'd2; n0 = out_q.size(); d0 = done_cnt;
    step(1'b0, '0, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 16; k++) step(1'b1, all_lanes(32'((k % 8) + 1)), 1'b0);
    idle(12);
    chk("t1_count", 32'(out_q.size() - n0), 32'd2);
    chk("t1_p0_l0", ln(out_q[n0], 0), 32'd36);
    chk("t1_p0_l7", ln(out_q[n0], 7), 32'd36);
    chk("t1_p1_l0", ln(out_q[n0+1], 0), 32'd36);
    chk("t1_p1_l5", ln(out_q[n0+1], 5), 32'd36);
    chk("t1_done_p0", 32'(done_at[n0]), 32'd0);
    chk("t1_done_p1", 32'(done_at[n0+1]), 32'd1);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // N=1, P=4, lane 0 carries 5,-3,0,7
    n_in = 16'd1; p_in = 20'd4; n0 = out_q.size();
    step(1'b0, '0, 1'b1);
    c_first = cyc;
    step(1'b1, one_lane(0, 32'd5), 1'b0);
    step(1'b1, one_lane(0, 32'hFFFF_FFFD), 1'b0);
    step(1'b1, one_lane(0, 32'd0), 1'b0);
    step(1'b1, one_lane(0, 32'd7), 1'b0);
    idle(12);
    chk("t2_count", 32'(out_q.size() - n0), 32'd4);
    chk("t2_v0", ln(out_q[n0], 0), 32'd5);
    chk("t2_v1", ln(out_q[n0+1], 0), 32'hFFFF_FFFD);
    chk("t2_v2", ln(out_q[n0+2], 0), 32'd0);
    chk("t2_v3", ln(out_q[n0+3], 0), 32'd7);
    chk("t2_latency", 32'(cyc_at[n0] - c_first), 32'd8);
    chk("t2_back2back", 32'(cyc_at[n0+3] - cyc_at[n0]), 32'd3);
    chk("t2_done_last", 32'(done_at[n0+3]), 32'd1);
    chk("t2_done_mid", 32'(done_at[n0+2]), 32'd0);

    // N=2 wrap in lane 3, independent sum in lane 0
    n_in = 16'd2; p_in = 20'd1; n0 = out_q.size();
    step(1'b0, '0, 1'b1);
    step(1'b1, one_lane(3, 32'h7FFF_FFFF) | one_lane(0, 32'd1), 1'b0);
    step(1'b1, one_lane(3, 32'h7FFF_FFFF) | one_lane(0, 32'd2), 1'b0);
    idle(12);
    chk("t3_count", 32'(out_q.size() - n0), 32'd1);
    chk("t3_l3_wrap", ln(out_q[n0], 3), 32'hFFFF_FFFE);
    chk("t3_l0", ln(out_q[n0], 0), 32'd3);
    chk("t3_l4", ln(out_q[n0], 4), 32'd0);
    chk("t3_hold_l3", ln(data_out, 3), 32'hFFFF_FFFE);
    chk("t3_hold_valid", 32'(data_out_valid), 32'd0);

    // N=4 with 3-cycle gaps between beats: 100 - 50 + 300 + 1000 = 1350
    n_in = 16'd4; p_in = 20'd1; n0 = out_q.size();
    step(1'b0, '0, 1'b1);
    step(1'b1, one_lane(1, 32'd100), 1'b0);          idle(3);
    step(1'b1, one_lane(1, 32'hFFFF_FFCE), 1'b0);    idle(3);
    step(1'b1, one_lane(1, 32'd300), 1'b0);          idle(3);
    chk("t4_no_early", 32'(out_q.size() - n0), 32'd0);
    step(1'b1, one_lane(1, 32'd1000), 1'b0);
    idle(12);
    chk("t4_count", 32'(out_q.size() - n0), 32'd1);
    chk("t4_sum", ln(out_q[n0], 1), 32'd1350);

    // reset after 2 of 4 beats, then a fresh pass of four 10s
    n_in = 16'd4; p_in = 20'd1; n0 = out_q.size();
    step(1'b0, '0, 1'b1);
    step(1'b1, one_lane(2, 32'd10), 1'b0);
    step(1'b1, one_lane(2, 32'd10), 1'b0);
    idle(10);
    chk("t5_busy_mid", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_data", 32'(|data_out), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_valid", 32'(data_out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_no_partial", 32'(out_q.size() - n0), 32'd0);
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, one_lane(2, 32'd10), 1'b0);
    idle(12);
    chk("t5_count", 32'(out_q.size() - n0), 32'd1);
    chk("t5_sum", ln(out_q[n0], 2), 32'd40);

    // start during RUN with different N/P must be ignored
    n_in = 16'd2; p_in = 20'd2; n0 = out_q.size();
    step(1'b0, '0, 1'b1);
    step(1'b1, one_lane(0, 32'd1), 1'b0);
    n_in = 16'd5; p_in = 20'd9;
    step(1'b1, one_lane(0, 32'd2), 1'b1);
    step(1'b1, one_lane(0, 32'd3), 1'b0);
    step(1'b1, one_lane(0, 32'd4), 1'b0);
    idle(12);
    chk("t6_count", 32'(out_q.size() - n0), 32'd2);
    chk("t6_p0", ln(out_q[n0], 0), 32'd3);
    chk("t6_p1", ln(out_q[n0+1], 0), 32'd7);
    chk("t6_done", 32'(done_at[n0+1]), 32'd1);
    chk("t6_busy_end", 32'(busy), 32'd0);

    // P=0 gives RUN, DONE, IDLE with no output
    n_in = 16'd3; p_in = 20'd0; n0 = out_q.size();
    step(1'b0, '0, 1'b1);
    chk("t7_run_busy", 32'(busy), 32'd1);
    chk("t7_run_done", 32'(done), 32'd0);
    idle(1);
    chk("t7_done_busy", 32'(busy), 32'd1);
    chk("t7_done_pulse", 32'(done), 32'd1);
    idle(1);
    chk("t7_idle_busy", 32'(busy), 32'd0);
    chk("t7_idle_done", 32'(done), 32'd0);
    idle(4);
    chk("t7_no_output", 32'(out_q.size() - n0), 32'd0);

    // N=0 behaves as N=1
    n_in = 16'd0; p_in = 20'd2; n0 = out_q.size();
    step(1'b0, '0, 1'b1);
    step(1'b1, one_lane(5, 32'd9), 1'b0);
    step(1'b1, one_lane(5, 32'd11), 1'b0);
    idle(12);
    chk("t8_count", 32'(out_q.size() - n0), 32'd2);
    chk("t8_p0", ln(out_q[n0], 5), 32'd9);
    chk("t8_p1", ln(out_q[n0+1], 5), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/channel_in_group_acc.md
CHANNEL_IN_GROUP_ACC -- requirements
Module: channel_in_group_acc

Interface
REQ-001 SHALL take parameter TREE_LATENCY, default 7, as the cycles from the adder-tree input to the adder-tree output.
REQ-002 SHALL take lane count and lane width from the shared macros: `PICTURE_NUM lanes of `WIDTH_DATA_OUT*2 bits each, as signed two's complement.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a layer pass.
REQ-006 SHALL have port channel_in_times, input, 16 bits: N, the number of tree beats per output pixel; it is sampled on start.
REQ-007 SHALL have port pixel_total, input, 20 bits: P, the number of output pixels per pass; it is sampled on start.
REQ-008 SHALL have port valid_in, input, 1 bit: marks a beat entering the adder tree, asserted in the same cycle as the tree's data_in.
REQ-009 SHALL have port data_in, input, `PICTURE_NUM*`WIDTH_DATA_OUT*2 bits: the adder-tree data_out.
REQ-010 SHALL have port data_out, output, same width as data_in: the accumulated pixel sum.
REQ-011 SHALL have port data_out_valid, output, 1 bit: one-cycle qualifier for data_out.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a pass.

Function
REQ-014 SHALL delay valid_in through a TREE_LATENCY-deep shift register; its output, v_al, is aligned with data_in.
REQ-015 SHALL implement the FSM IDLE -> RUN on start; RUN -> DONE when the P-th pixel is emitted; DONE -> IDLE after 1 cycle.
REQ-016 SHALL ignore start while in RUN or DONE.
REQ-017 SHALL ignore v_al while in IDLE or DONE; the shift register keeps running in every state.
REQ-018 SHALL treat a sampled N=0 as N=1, and a sampled P=0 as an immediate RUN -> DONE with no output beats.
REQ-019 SHALL handle each v_al beat in RUN per lane as follows: beat_cnt=0 loads acc with data_in; any other beat adds data_in to acc.
REQ-020 SHALL do all lane additions independently per lane, at the lane width, wrapping modulo 2^(2*`WIDTH_DATA_OUT), with no saturation and no cross-lane carry.
REQ-021 SHALL, on the beat where beat_cnt=N-1, register data_out as acc+data_in (or data_in when N=1), assert data_out_valid in the next cycle, and reset beat_cnt to 0.
REQ-022 SHALL accept back-to-back v_al beats on every cycle with no stall; a pixel's last beat and the next pixel's first beat MAY be adjacent.
REQ-023 SHALL increment pixel_cnt on each emitted pixel, and assert done in the same cycle as the final data_out_valid.
REQ-024 SHALL hold data_out at its last value when data_out_valid is low.
REQ-025 SHALL drop v_al gaps silently: the accumulator holds across idle cycles.

Reset
REQ-026 SHALL, on rst high and regardless of clk, clear the state to IDLE and clear to zero the shift register, beat_cnt, pixel_cnt, acc, data_out, data_out_valid, busy and done.
REQ-027 SHALL abandon any pass that is mid-RUN when rst is asserted, with no partial output; the first start after reset release begins a fresh pass.

Structure
REQ-028 SHALL get `PICTURE_NUM and `WIDTH_DATA_OUT from the shared Para.v include, and SHALL add TREE_LATENCY_DEFAULT=7 and the FSM state encodings there.
REQ-029 SHALL use one sub-module, valid_delay_line (a parameterised depth, 1-bit, async-reset shift register); the lane adders are inline.

Verification (PICTURE_NUM=8, WIDTH_DATA_OUT=16, lane=32 bits)
REQ-030 SHALL cover N=8, P=2, with all lanes receiving values 1..8 on consecutive aligned beats: data_out_valid is high 2 times, each lane reads 36, and done coincides with the 2nd valid.
REQ-031 SHALL cover N=1, P=4, with inputs 5,-3,0,7 in lane 0: four consecutive valids carrying 5, 0xFFFFFFFD, 0 and 7, and first valid appearing TREE_LATENCY+1 cycles after the first valid_in.
REQ-032 SHALL cover wrap-around with N=2, lane 3 = 0x7FFFFFFF twice: output 0xFFFFFFFE, with other lanes unaffected.
REQ-033 SHALL cover N=4 with valid_in gaps of 3 cycles between beats: the sum is correct and exactly one valid is produced per 4 beats.
REQ-034 SHALL cover rst asserted after 2 of 4 beats: all outputs are 0 immediately; then start with N=4, P=1 and beats of 10 give exactly one output of 40, with no carry-over.
REQ-035 SHALL cover start pulsed during RUN: it is ignored, and the sampled N and P are unchanged.
